ssg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-anode seven-segment display.

---
 rtl/ssg_scan_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ssg_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ssg_scan_ctrl.sv
// Seven-segment scan controller: double-buffered N-digit hex value,
// time-multiplexed onto an active-low digit select with dead time.
module ssg_scan_ctrl #(
  parameter int NDIGITS  = 8,
  parameter int ON_CYC   = 1000,
  parameter int DEAD_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 lz_blank,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [4*NDIGITS-1:0] load_data,
  output logic [7:0]           digit_code,
  output logic [NDIGITS-1:0]   digit_sel,
  output logic                 frame_done
);

  localparam int MAXC = (ON_CYC > DEAD_CYC) ? ON_CYC : DEAD_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(NDIGITS);
  localparam bit HAS_DEAD = (DEAD_CYC > 0);

  localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] DEAD_LAST =
    CW'(HAS_DEAD ? DEAD_CYC - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    ON
  } state_e;

  localparam state_e START = HAS_DEAD ? DEAD : ON;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [4*NDIGITS-1:0] shadow_q, shadow_d;
  logic [4*NDIGITS-1:0] active_q, active_d;
  logic                 pending_q, pending_d;
  logic                 rdy_q;
  logic                 fd_q, fd_d;
  logic [NDIGITS-1:0]   sel_q, sel_d;
  logic [3:0]           code_q, code_d;
  logic                 bnd_d;
  logic                 xfer;
  logic                 on_end;
  logic                 wrap;

  assign xfer   = load_valid & rdy_q;
  assign on_end = (state_q == ON) && (cnt_q == ON_LAST);
  assign wrap   = on_end && (idx_q == IDX_LAST);

  // Digit i>0 is a leading zero when nibbles i..N-1 are all zero.
  function automatic logic blank_f(
    input logic [4*NDIGITS-1:0] v,
    input logic [IW-1:0]        i
  );
    logic nz;
    nz = 1'b0;
    for (int j = 1; j < NDIGITS; j++) begin
      if (j >= int'(i) && v[4*j +: 4] != 4'h0) nz = 1'b1;
    end
    return (i != '0) && !nz;
  endfunction

  // Scan sequencing: IDLE -> DEAD -> ON per digit, frame boundary on wrap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    bnd_d   = 1'b0;
    fd_d    = 1'b0;
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = START;
          idx_d   = '0;
          cnt_d   = '0;
          bnd_d   = 1'b1;
        end
        DEAD: begin
          if (cnt_q == DEAD_LAST) begin
            state_d = ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ON: begin
          if (on_end) begin
            state_d = START;
            cnt_d   = '0;
            idx_d   = wrap ? '0 : idx_q + 1'b1;
            bnd_d   = wrap;
            fd_d    = wrap;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Double buffer: swap only at a boundary, otherwise accept a load.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (bnd_d && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (xfer) begin
      shadow_d  = load_data;
      pending_d = 1'b1;
    end
  end

  // Next-cycle digit select and code, so outputs leave flops directly.
  always_comb begin
    sel_d  = '1;
    code_d = 4'h0;
    if (state_d == ON) begin
      code_d = active_d[4*idx_d +: 4];
      if (!(lz_blank && blank_f(active_d, idx_d))) begin
        sel_d[idx_d] = 1'b0;
      end
    end
  end

  // State and output registers, async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      rdy_q     <= 1'b1;
      fd_q      <= 1'b0;
      sel_q     <= '1;
      code_q    <= 4'h0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      rdy_q     <= ~pending_d;
      fd_q      <= fd_d;
      sel_q     <= sel_d;
      code_q    <= code_d;
    end
  end

  assign load_ready = rdy_q;
  assign frame_done = fd_q;
  assign digit_sel  = sel_q;
  assign digit_code = {4'h0, code_q};

endmodule

// File: tb/tb_ssg_scan_ctrl.sv
// Scoreboard bench for ssg_scan_ctrl (4 digits, ON=3, DEAD=1).
// Stimulus queues per-cycle expectations; a negedge monitor checks them.
module tb_ssg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        lz_blank;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [7:0]  digit_code;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int cyc    = 0;
  int errs   = 0;
  int checks = 0;

  typedef struct {
    int         tag;
    logic [3:0] sel;
    logic [7:0] code;
    bit         cchk;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t q[$];

  ssg_scan_ctrl #(
    .NDIGITS (4),
    .ON_CYC  (3),
    .DEAD_CYC(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .lz_blank  (lz_blank),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .digit_code(digit_code),
    .digit_sel (digit_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cycle %0d: got %0h want %0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic push_e(input int tag, input logic [3:0] sel,
                        input logic [3:0] code, input bit cc,
                        input logic fd, input logic rdy);
    exp_t e;
    e.tag  = tag;
    e.sel  = sel;
    e.code = {4'h0, code};
    e.cchk = cc;
    e.fd   = fd;
    e.rdy  = rdy;
    q.push_back(e);
  endtask

  // One frame of n cycles starting at cycle s: DEAD, then 3 ON per digit.
  task automatic push_frame(input int s, input logic [15:0] v,
                            input bit lz, input logic fd0,
                            input logic [15:0] rmask, input int n);
    int         d;
    int         ph;
    logic [3:0] sel;
    logic [3:0] nib;
    for (int k = 0; k < n; k++) begin
      d   = k / 4;
      ph  = k % 4;
      nib = v[4*d +: 4];
      if (ph == 0) begin
        push_e(s + k, 4'hF, 4'h0, 1'b0,
               (d == 0) ? fd0 : 1'b0, rmask[k]);
      end else begin
        sel = 4'hF;
        if (!(lz && d > 0 && (v >> (4*d)) == 16'h0)) sel[d] = 1'b0;
        push_e(s + k, sel, nib, 1'b1, 1'b0, rmask[k]);
      end
    end
  endtask

  // Monitor: compare whatever expectation is scheduled for this cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() != 0 && q[0].tag < cyc) begin
      checks++;
      errs++;
      $display("FAIL sched cycle %0d: got tag %0d want %0d",
               cyc, q[0].tag, cyc);
      void'(q.pop_front());
    end
    if (q.size() != 0 && q[0].tag == cyc) begin
      e = q.pop_front();
      chk("digit_sel", 32'(digit_sel), 32'(e.sel));
      chk("frame_done", 32'(frame_done), 32'(e.fd));
      chk("load_ready", 32'(load_ready), 32'(e.rdy));
      if (e.cchk) chk("digit_code", 32'(digit_code), 32'(e.code));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int b, s2, s3, s4, s5, s6, s7, s8, s9, r;
    rst_n      = 1'b0;
    en         = 1'b0;
    lz_blank   = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0;
    #7;
    chk("rst_sel", 32'(digit_sel), 32'hF);
    chk("rst_code", 32'(digit_code), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h1);
    chk("rst_fd", 32'(frame_done), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    b  = cyc;
    s2 = b + 18;
    s3 = s2 + 16;
    s4 = s3 + 16;
    s5 = s4 + 16;
    s6 = s5 + 16;
    s7 = s6 + 16;
    s8 = s7 + 16;
    s9 = s8 + 13;

    // Test 1: load 1234 while idle, then enable.
    push_e(b, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1);
    push_e(b + 1, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
    push_frame(b + 2, 16'h1234, 1'b0, 1'b0, 16'hFFFF, 16);
    push_frame(s2, 16'h1234, 1'b0, 1'b1, 16'h003F, 16);
    load_valid = 1'b1;
    load_data  = 16'h1234;
    tick();
    load_valid = 1'b0;
    en         = 1'b1;

    // Test 2: load ABCD while digit 1 is lit.
    wait_to(s2 + 5);
    push_frame(s3, 16'hABCD, 1'b0, 1'b1, 16'h0003, 16);
    load_valid = 1'b1;
    load_data  = 16'hABCD;
    tick();
    load_valid = 1'b0;

    // Test 3: hold valid across 1111 then 2222.
    wait_to(s3 + 1);
    push_frame(s4, 16'h1111, 1'b0, 1'b1, 16'h0001, 16);
    load_valid = 1'b1;
    load_data  = 16'h1111;
    tick();
    load_data  = 16'h2222;
    wait_to(s4 + 1);
    load_valid = 1'b0;
    push_frame(s5, 16'h2222, 1'b0, 1'b1, 16'hFFFF, 16);

    // Test 4: load 0050 in the boundary cycle, blanking on.
    wait_to(s5 + 15);
    push_frame(s6, 16'h2222, 1'b1, 1'b1, 16'h0000, 16);
    load_valid = 1'b1;
    load_data  = 16'h0050;
    lz_blank   = 1'b1;
    tick();
    load_valid = 1'b0;
    wait_to(s6 + 1);
    push_frame(s7, 16'h0050, 1'b1, 1'b1, 16'h0003, 16);
    wait_to(s7 + 1);
    push_frame(s8, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 10);
    load_valid = 1'b1;
    load_data  = 16'h0000;
    tick();
    load_valid = 1'b0;

    // Test 5: disable during digit 2, load while idle, re-enable.
    wait_to(s8 + 9);
    en = 1'b0;
    push_e(s8 + 10, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1);
    push_e(s8 + 11, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
    push_e(s8 + 12, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    load_valid = 1'b1;
    load_data  = 16'h9876;
    lz_blank   = 1'b0;
    tick();
    load_valid = 1'b0;
    tick();
    en = 1'b1;
    push_frame(s9, 16'h9876, 1'b0, 1'b0, 16'h0003, 6);

    // Test 6: async reset mid-frame with a pending load.
    wait_to(s9 + 1);
    load_valid = 1'b1;
    load_data  = 16'h5555;
    tick();
    load_valid = 1'b0;
    wait_to(s9 + 6);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("arst_sel", 32'(digit_sel), 32'hF);
    chk("arst_code", 32'(digit_code), 32'h0);
    chk("arst_ready", 32'(load_ready), 32'h1);
    chk("arst_fd", 32'(frame_done), 32'h0);
    tick();
    tick();
    r     = cyc;
    rst_n = 1'b1;
    en    = 1'b1;
    push_e(r, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1);
    push_frame(r + 1, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 16);
    wait_to(r + 17);
    chk("drain", 32'(q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
